// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack round controller: state encoding,
// result codes, rule defaults and the rank-to-value mapping.
package blackjack_pkg;

  localparam int unsigned DEALER_STAND_DEF = 17;
  localparam int unsigned BUST_LIMIT_DEF   = 21;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DEAL_P1 = 4'd1,
    ST_DEAL_D1 = 4'd2,
    ST_DEAL_P2 = 4'd3,
    ST_DEAL_D2 = 4'd4,
    ST_P_TURN  = 4'd5,
    ST_P_HIT   = 4'd6,
    ST_P_CHECK = 4'd7,
    ST_D_TURN  = 4'd8,
    ST_D_HIT   = 4'd9,
    ST_DONE    = 4'd10
  } state_e;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  typedef struct packed {
    logic [4:0] value;
    logic       is_ace;
  } card_val_t;

  // Aces count 1 here; the soft +10 is applied by the hand accumulator.
  function automatic card_val_t card_value(input logic [3:0] rank);
    card_val_t cv;
    cv.value  = 5'd10;
    cv.is_ace = 1'b0;
    if (rank == 4'd1) begin
      cv.value  = 5'd1;
      cv.is_ace = 1'b1;
    end else if (rank >= 4'd2 && rank <= 4'd9) begin
      cv.value = {1'b0, rank};
    end
    return cv;
  endfunction

endpackage

// File: rtl/bj_hand_accum.sv
// One blackjack hand: hard sum, ace flag and card count, with the soft-ace
// effective total derived combinationally from the registered state.
module bj_hand_accum
  import blackjack_pkg::*;
#(
  parameter int unsigned BUST_LIMIT = BUST_LIMIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [3:0] rank_i,
  output logic [4:0] hard_sum_o,
  output logic       has_ace_o,
  output logic [4:0] eff_total_o,
  output logic [3:0] card_count_o
);

  localparam logic [5:0] BUST6 = 6'(BUST_LIMIT);

  card_val_t  cv;
  logic [4:0] hard_sum_q, hard_sum_d;
  logic       has_ace_q, has_ace_d;
  logic [3:0] card_count_q, card_count_d;
  logic [5:0] soft_sum;

  assign cv = card_value(rank_i);

  always_comb begin
    hard_sum_d   = hard_sum_q;
    has_ace_d    = has_ace_q;
    card_count_d = card_count_q;
    if (clear_i) begin
      hard_sum_d   = 5'd0;
      has_ace_d    = 1'b0;
      card_count_d = 4'd0;
    end else if (add_i) begin
      hard_sum_d   = hard_sum_q + cv.value;
      has_ace_d    = has_ace_q | cv.is_ace;
      card_count_d = card_count_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hard_sum_q   <= 5'd0;
      has_ace_q    <= 1'b0;
      card_count_q <= 4'd0;
    end else begin
      hard_sum_q   <= hard_sum_d;
      has_ace_q    <= has_ace_d;
      card_count_q <= card_count_d;
    end
  end

  // Six bits so a hard sum near 30 cannot wrap into a falsely "safe" soft total.
  assign soft_sum     = {1'b0, hard_sum_q} + 6'd10;
  assign eff_total_o  = (has_ace_q && soft_sum <= BUST6) ? soft_sum[4:0] : hard_sum_q;
  assign hard_sum_o   = hard_sum_q;
  assign has_ace_o    = has_ace_q;
  assign card_count_o = card_count_q;

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Round-level blackjack controller: deals from the deck over req/ack, runs the
// player turn and dealer draw rule, and reports the round result.
module blackjack_round_ctrl
  import blackjack_pkg::*;
#(
  parameter int unsigned DEALER_STAND = DEALER_STAND_DEF,
  parameter int unsigned BUST_LIMIT   = BUST_LIMIT_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       hit_pressed,
  input  logic       stand_pressed,
  input  logic       deal_pressed,
  output logic       card_req,
  input  logic       card_ack,
  input  logic [3:0] card_rank,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [3:0] player_cards,
  output logic [3:0] dealer_cards,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [3:0] state_dbg
);

  localparam logic [4:0] BUST5  = 5'(BUST_LIMIT);
  localparam logic [4:0] STAND5 = 5'(DEALER_STAND);

  state_e     state_q, state_d;
  logic [1:0] result_q, result_d;
  logic       clear_hands, add_player, add_dealer, ack_ok;
  logic [4:0] p_hard, d_hard, p_eff, d_eff;
  logic       p_ace, d_ace;
  logic       unused_ace;
  logic [1:0] cmp_result;

  bj_hand_accum #(.BUST_LIMIT(BUST_LIMIT)) u_player (
    .clk_i       (CLOCK_50),
    .rst_i       (reset),
    .clear_i     (clear_hands),
    .add_i       (add_player),
    .rank_i      (card_rank),
    .hard_sum_o  (p_hard),
    .has_ace_o   (p_ace),
    .eff_total_o (p_eff),
    .card_count_o(player_cards)
  );

  bj_hand_accum #(.BUST_LIMIT(BUST_LIMIT)) u_dealer (
    .clk_i       (CLOCK_50),
    .rst_i       (reset),
    .clear_i     (clear_hands),
    .add_i       (add_dealer),
    .rank_i      (card_rank),
    .hard_sum_o  (d_hard),
    .has_ace_o   (d_ace),
    .eff_total_o (d_eff),
    .card_count_o(dealer_cards)
  );

  assign unused_ace = p_ace ^ d_ace;

  assign card_req = (state_q == ST_DEAL_P1) || (state_q == ST_DEAL_D1) ||
                    (state_q == ST_DEAL_P2) || (state_q == ST_DEAL_D2) ||
                    (state_q == ST_P_HIT)   || (state_q == ST_D_HIT);
  assign ack_ok   = card_req && card_ack;

  // A hand is bust exactly when its hard sum is (the soft bonus is never applied then).
  always_comb begin
    if (d_hard > BUST5)      cmp_result = RES_PLAYER;
    else if (p_eff > d_eff)  cmp_result = RES_PLAYER;
    else if (p_eff < d_eff)  cmp_result = RES_DEALER;
    else                     cmp_result = RES_PUSH;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    clear_hands = 1'b0;
    add_player  = 1'b0;
    add_dealer  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (deal_pressed) begin
          clear_hands = 1'b1;
          result_d    = RES_NONE;
          state_d     = ST_DEAL_P1;
        end
      end
      ST_DEAL_P1: if (ack_ok) begin add_player = 1'b1; state_d = ST_DEAL_D1; end
      ST_DEAL_D1: if (ack_ok) begin add_dealer = 1'b1; state_d = ST_DEAL_P2; end
      ST_DEAL_P2: if (ack_ok) begin add_player = 1'b1; state_d = ST_DEAL_D2; end
      ST_DEAL_D2: if (ack_ok) begin add_dealer = 1'b1; state_d = ST_P_TURN;  end
      ST_P_TURN: begin
        if (p_eff == BUST5)     state_d = ST_D_TURN;
        else if (stand_pressed) state_d = ST_D_TURN;
        else if (hit_pressed)   state_d = ST_P_HIT;
      end
      ST_P_HIT: if (ack_ok) begin add_player = 1'b1; state_d = ST_P_CHECK; end
      ST_P_CHECK: begin
        if (p_hard > BUST5) begin
          result_d = RES_DEALER;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_P_TURN;
        end
      end
      ST_D_TURN: begin
        if (d_eff < STAND5) begin
          state_d  = ST_D_HIT;
        end else begin
          result_d = cmp_result;
          state_d  = ST_DONE;
        end
      end
      ST_D_HIT: if (ack_ok) begin add_dealer = 1'b1; state_d = ST_D_TURN; end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign player_total = p_eff;
  assign dealer_total = d_eff;
  assign result       = result_q;
  assign result_valid = (state_q == ST_DONE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed self-checking bench for blackjack_round_ctrl: table of full rounds
// plus hand-written handshake, key-press and mid-round reset sequences.
module tb_blackjack_round_ctrl;
  import blackjack_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       hit_pressed, stand_pressed, deal_pressed;
  logic       card_req, card_ack;
  logic [3:0] card_rank;
  logic [4:0] player_total, dealer_total;
  logic [3:0] player_cards, dealer_cards;
  logic [1:0] result;
  logic       result_valid;
  logic [3:0] state_dbg;

  blackjack_round_ctrl dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .hit_pressed  (hit_pressed),
    .stand_pressed(stand_pressed),
    .deal_pressed (deal_pressed),
    .card_req     (card_req),
    .card_ack     (card_ack),
    .card_rank    (card_rank),
    .player_total (player_total),
    .dealer_total (dealer_total),
    .player_cards (player_cards),
    .dealer_cards (dealer_cards),
    .result       (result),
    .result_valid (result_valid),
    .state_dbg    (state_dbg)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int ranks[6];
    int n;
    int hits;
    bit stand;
    int exp_res;
    int exp_p;
    int exp_d;
    int exp_pc;
    int exp_dc;
  } vec_t;

  vec_t       vecs[8];
  logic [3:0] deck[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hit_pressed   = 1'b0;
    stand_pressed = 1'b0;
    deal_pressed  = 1'b0;
    card_ack      = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".state"}, state_dbg, ST_IDLE);
    chk({tag, ".req"}, card_req, 0);
    chk({tag, ".ptot"}, player_total, 0);
    chk({tag, ".dtot"}, dealer_total, 0);
    chk({tag, ".pcards"}, player_cards, 0);
    chk({tag, ".dcards"}, dealer_cards, 0);
    chk({tag, ".result"}, result, 0);
    chk({tag, ".valid"}, result_valid, 0);
  endtask

  task automatic start_deal(input string tag);
    deal_pressed = 1'b1;
    @(negedge CLOCK_50);
    deal_pressed = 1'b0;
    chk({tag, ".deal_state"}, state_dbg, ST_DEAL_P1);
    chk({tag, ".deal_req"}, card_req, 1);
    chk({tag, ".deal_pcards"}, player_cards, 0);
    chk({tag, ".deal_dcards"}, dealer_cards, 0);
    chk({tag, ".deal_result"}, result, 0);
    chk({tag, ".deal_valid"}, result_valid, 0);
  endtask

  // Serves deck cards on request and plays the given policy until DONE.
  task automatic run_to_done(input string tag, input int n_hits, input bit press_stand,
                             output int used);
    int hits = n_hits;
    int budget = 0;
    used = 0;
    while (state_dbg != ST_DONE && budget < 300) begin
      idle_inputs();
      if (card_req) begin
        if (deck.size() == 0) begin
          chk({tag, ".deck_empty_req"}, 1, 0);
          break;
        end
        card_ack  = 1'b1;
        card_rank = deck.pop_front();
        used++;
      end else if (state_dbg == ST_P_TURN) begin
        if (hits > 0) begin
          hit_pressed = 1'b1;
          hits--;
        end else if (press_stand) begin
          stand_pressed = 1'b1;
        end
      end
      @(negedge CLOCK_50);
      budget++;
    end
    idle_inputs();
    chk({tag, ".reached_done"}, state_dbg, ST_DONE);
  endtask

  task automatic feed_until(input string tag, input int target);
    int budget = 0;
    while (state_dbg != target && budget < 50) begin
      idle_inputs();
      if (card_req && deck.size() > 0) begin
        card_ack  = 1'b1;
        card_rank = deck.pop_front();
      end
      @(negedge CLOCK_50);
      budget++;
    end
    idle_inputs();
    chk({tag, ".feed_state"}, state_dbg, target);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int used;
    deck.delete();
    for (int j = 0; j < v.n; j++) deck.push_back(4'(v.ranks[j]));
    start_deal(tag);
    run_to_done(tag, v.hits, v.stand, used);
    chk({tag, ".cards_used"}, used, v.n);
    chk({tag, ".result"}, result, v.exp_res);
    chk({tag, ".valid"}, result_valid, 1);
    chk({tag, ".ptot"}, player_total, v.exp_p);
    chk({tag, ".dtot"}, dealer_total, v.exp_d);
    chk({tag, ".pcards"}, player_cards, v.exp_pc);
    chk({tag, ".dcards"}, dealer_cards, v.exp_dc);
    @(negedge CLOCK_50);
    chk({tag, ".req_after_done"}, card_req, 0);
    chk({tag, ".result_held"}, result, v.exp_res);
    $display("%s: result=%0d player=%0d/%0d cards dealer=%0d/%0d cards",
             tag, result, player_total, player_cards, dealer_total, dealer_cards);
  endtask

  initial begin
    //           ranks               n  hits stand res  p   d  pc dc
    vecs[0] = '{'{10, 7, 9, 5, 6, 0}, 5, 0, 1'b1, 1, 19, 18, 2, 3};
    vecs[1] = '{'{1, 10, 13, 6, 2, 0}, 5, 0, 1'b0, 1, 21, 18, 2, 3};
    vecs[2] = '{'{10, 9, 6, 8, 12, 0}, 5, 1, 1'b1, 2, 26, 17, 3, 2};
    vecs[3] = '{'{10, 1, 7, 6, 0, 0}, 4, 0, 1'b1, 3, 17, 17, 2, 2};
    vecs[4] = '{'{10, 10, 10, 6, 10, 0}, 5, 0, 1'b1, 1, 20, 26, 2, 3};
    vecs[5] = '{'{10, 10, 7, 9, 0, 0}, 4, 0, 1'b1, 2, 17, 19, 2, 2};
    vecs[6] = '{'{1, 10, 5, 6, 9, 5}, 6, 1, 1'b1, 2, 15, 21, 3, 3};
    vecs[7] = '{'{5, 10, 6, 8, 10, 0}, 5, 1, 1'b0, 1, 21, 18, 3, 2};

    reset     = 1'b1;
    card_rank = 4'd0;
    idle_inputs();
    repeat (3) @(negedge CLOCK_50);
    check_cleared("reset");
    reset = 1'b0;
    card_ack  = 1'b1;
    card_rank = 4'd5;
    @(negedge CLOCK_50);
    idle_inputs();
    check_cleared("idle_spurious_ack");
    $display("reset: state=%0d req=%0d", state_dbg, card_req);

    for (int i = 0; i < 8; i++) run_vec($sformatf("round%0d", i), vecs[i]);

    // Ack withheld while dealing, then spurious ack/deal in P_TURN, then hit+stand together.
    start_deal("hs");
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      chk($sformatf("hs.wait%0d_req", k), card_req, 1);
      chk($sformatf("hs.wait%0d_state", k), state_dbg, ST_DEAL_P1);
    end
    chk("hs.wait_pcards", player_cards, 0);
    deck = '{4'd10, 4'd7, 4'd9, 4'd5};
    feed_until("hs", ST_P_TURN);
    card_ack     = 1'b1;
    card_rank    = 4'd5;
    deal_pressed = 1'b1;
    @(negedge CLOCK_50);
    deal_pressed = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    card_ack = 1'b0;
    chk("hs.spur_state", state_dbg, ST_P_TURN);
    chk("hs.spur_pcards", player_cards, 2);
    chk("hs.spur_dcards", dealer_cards, 2);
    chk("hs.spur_ptot", player_total, 19);
    chk("hs.spur_dtot", dealer_total, 12);
    hit_pressed   = 1'b1;
    stand_pressed = 1'b1;
    @(negedge CLOCK_50);
    idle_inputs();
    chk("hs.both_keys_state", state_dbg, ST_D_TURN);
    begin
      int used;
      deck = '{4'd6};
      run_to_done("hs", 0, 1'b0, used);
      chk("hs.used", used, 1);
    end
    chk("hs.result", result, 1);
    chk("hs.pcards", player_cards, 2);
    chk("hs.dtot", dealer_total, 18);
    $display("handshake: result=%0d player=%0d dealer=%0d", result, player_total, dealer_total);

    // Reset in the middle of a cycle while a hit card is outstanding.
    start_deal("rst");
    deck = '{4'd10, 4'd6, 4'd9, 4'd8};
    feed_until("rst", ST_P_TURN);
    hit_pressed = 1'b1;
    @(negedge CLOCK_50);
    hit_pressed = 1'b0;
    chk("rst.in_phit", state_dbg, ST_P_HIT);
    chk("rst.req_before", card_req, 1);
    #2 reset = 1'b1;
    #1 check_cleared("rst.async");
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check_cleared("rst.released");
    $display("midround reset: state=%0d req=%0d", state_dbg, card_req);
    run_vec("post_reset", vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
